uart_word_tx: RTL and testbench

Serializes 32-bit words from the core's `tx_word` path onto a single UART line (8N1, little-endian byte order, LSB-first bits), so that software running on `Core` can report results, including pass/fail signatures, to a host terminal. It takes words over a valid/ready handshake, holds each word internally, and sends it as four back-to-back UART frames. It sits between `Core` and the FPGA TX pin, and is the transmit end for the host-side (or bench-side) UART receiver.

---
 rtl/uart_word_if.sv | 13 +
 rtl/uart_word_tx.sv | 106 ++++++++++
 tb/tb_uart_word_tx.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_if.sv
// uart_word_if: word handshake between a producer (e.g. the core) and uart_word_tx.
//   word_in    [31:0] word offered by the producer
//   word_valid        producer has a word on word_in
//   word_ready        transmitter can accept a word this cycle
// master = producer side, slave = transmitter side.
interface uart_word_if;
   logic [31:0] word_in;
   logic        word_valid;
   logic        word_ready;

   modport master (output word_in, output word_valid, input word_ready);
   modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends each accepted 32-bit word as four 8N1 UART frames,
// low byte first, LSB-first within a byte, with no gap between frames.
//   clk, rst_n   system clock, asynchronous active-low reset
//   wif (slave)  word_in / word_valid / word_ready handshake
//   tx           serial line, idles high
//   busy         a word is being serialized
//   done         one-cycle pulse as the last stop bit of a word ends
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 234
) (
   input  logic        clk,
   input  logic        rst_n,
   uart_word_if.slave  wif,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [1:0]    byte_idx;
   logic [31:0]   shreg;
   logic          bit_end;

   assign bit_end        = (baud_cnt == BAUD_LAST);
   assign wif.word_ready = (state == IDLE);
   assign busy           = (state != IDLE);

   // The word shifts right one bit per data bit, so after a byte's eight
   // data bits the next byte already sits at shreg[7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (wif.word_valid) begin
                  shreg    <= wif.word_in;
                  byte_idx <= '0;
                  bit_idx  <= '0;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shreg[0];
                  shreg    <= {1'b0, shreg[31:1]};
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[31:1]};
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (byte_idx == 2'd3) begin
                     tx    <= 1'b1;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     // next frame's start bit follows the stop bit directly
                     byte_idx <= byte_idx + 2'd1;
                     tx       <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;
   localparam int C4 = 4;
   localparam int C2 = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic tx4, busy4, done4, tx2, busy2, done2;

   uart_word_if if4 ();
   uart_word_if if2 ();

   uart_word_tx #(.CLKS_PER_BIT(C4)) u4 (.clk(clk), .rst_n(rst_n), .wif(if4.slave),
                                         .tx(tx4), .busy(busy4), .done(done4));
   uart_word_tx #(.CLKS_PER_BIT(C2)) u2 (.clk(clk), .rst_n(rst_n), .wif(if2.slave),
                                         .tx(tx2), .busy(busy2), .done(done2));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [7:0] rxq4[$];
   logic [7:0] rxq2[$];

   typedef struct {
      bit          sel;     // 1 = C=2 instance
      logic [31:0] word;
      logic [3:0][7:0] exp; // exp[b] = b-th byte on the line
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic tx_of(bit s);   return s ? tx2 : tx4; endfunction
   function automatic logic rdy_of(bit s);  return s ? if2.word_ready : if4.word_ready; endfunction
   function automatic logic busy_of(bit s); return s ? busy2 : busy4; endfunction
   function automatic logic done_of(bit s); return s ? done2 : done4; endfunction
   function automatic int   c_of(bit s);    return s ? C2 : C4; endfunction

   task automatic drive(bit s, logic [31:0] w, logic v);
      if (s) begin if2.word_in = w; if2.word_valid = v; end
      else   begin if4.word_in = w; if4.word_valid = v; end
   endtask

   // Reference line level k cycles after the handshake edge: each byte is a
   // 10-bit frame {stop=1, data[7:0], start=0}, each bit c cycles wide.
   function automatic logic exp_tx(logic [31:0] w, int k, int c);
      int b, p;
      b = k / (10 * c);
      p = (k % (10 * c)) / c;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return w[8 * b + p - 1];
   endfunction

   // Bench UART receiver: mid-bit sampling on negedges, abandons a frame on reset.
   task automatic rx_run(bit s);
      int c;
      logic [7:0] b;
      bit ok;
      c = c_of(s);
      forever begin
         @(negedge clk);
         if (rst_n && tx_of(s) == 1'b0) begin
            ok = 1'b1;
            b  = '0;
            for (int k = 1; k <= c / 2 + 9 * c; k++) begin
               @(negedge clk);
               if (!rst_n) begin ok = 1'b0; break; end
               if (k == c / 2 && tx_of(s) != 1'b0) ok = 1'b0;
               if (k >= c / 2 + c && (k - c / 2) % c == 0) begin
                  if ((k - c / 2) / c - 1 < 8) b[(k - c / 2) / c - 1] = tx_of(s);
                  else if (tx_of(s) != 1'b1) ok = 1'b0;
               end
            end
            if (ok) begin
               if (s) rxq2.push_back(b); else rxq4.push_back(b);
            end
         end
      end
   endtask

   initial rx_run(1'b0);
   initial rx_run(1'b1);

   task automatic wait_ready(bit s);
      int guard = 0;
      while (!rdy_of(s) && guard < 2000) begin @(negedge clk); guard++; end
      if (guard >= 2000) chk("ready_timeout", 32'd0, 32'd1);
   endtask

   // One word with per-cycle waveform check against the model. glitch=1
   // also wiggles word_in/word_valid while the word is in flight.
   task automatic send(bit s, logic [31:0] w, bit glitch);
      int c;
      c = c_of(s);
      wait_ready(s);
      drive(s, w, 1'b1);
      @(posedge clk);                  // handshake edge T0
      @(negedge clk);
      drive(s, w, 1'b0);
      for (int k = 0; k < 40 * c; k++) begin
         chk($sformatf("tx k=%0d", k), 32'(tx_of(s)), 32'(exp_tx(w, k, c)));
         if (k == 0 || k == 40 * c - 1) begin
            chk("busy_during", 32'(busy_of(s)), 32'd1);
            chk("done_early", 32'(done_of(s)), 32'd0);
         end
         if (glitch) begin
            if (k >= 50 && k < 60 || k == 100) begin
               chk("ready_low_busy", 32'(rdy_of(s)), 32'd0);
               drive(s, ~w ^ 32'(k), 1'b1);
            end else drive(s, ~w, 1'b0);
         end
         @(negedge clk);
      end
      drive(s, w, 1'b0);
      chk("done_pulse", 32'(done_of(s)), 32'd1);
      chk("ready_at_done", 32'(rdy_of(s)), 32'd1);
      chk("busy_at_done", 32'(busy_of(s)), 32'd0);
      chk("tx_at_done", 32'(tx_of(s)), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done_of(s)), 32'd0);
   endtask

   task automatic check_bytes(bit s, int n, logic [7:0][7:0] exp, string name);
      int sz;
      sz = s ? rxq2.size() : rxq4.size();
      chk({name, "_count"}, 32'(sz), 32'(n));
      for (int i = 0; i < n && i < sz; i++)
         chk($sformatf("%s_byte%0d", name, i), 32'(s ? rxq2[i] : rxq4[i]), 32'(exp[i]));
      if (s) rxq2.delete(); else rxq4.delete();
   endtask

   vec_t vecs[3];
   logic [7:0][7:0] eb;
   logic [31:0] rw;

   initial begin
      vecs[0] = '{sel: 1'b0, word: 32'h4BA5_00FF, exp: {8'h4B, 8'hA5, 8'h00, 8'hFF}};
      vecs[1] = '{sel: 1'b1, word: 32'hAAAA_5555, exp: {8'hAA, 8'hAA, 8'h55, 8'h55}};
      vecs[2] = '{sel: 1'b0, word: 32'hDEAD_BEEF, exp: {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
      drive(1'b0, '0, 1'b0);
      drive(1'b1, '0, 1'b0);

      // reset asserted between edges: outputs must go idle at once
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tx", 32'(tx4), 32'd1);
      chk("rst_ready", 32'(if4.word_ready), 32'd1);
      chk("rst_busy", 32'(busy4), 32'd0);
      chk("rst_done", 32'(done4), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_tx", 32'(tx4), 32'd1);
      chk("idle_ready", 32'(if4.word_ready), 32'd1);
      chk("idle_busy", 32'(busy4), 32'd0);
      chk("idle_done", 32'(done4), 32'd0);

      // table vectors
      foreach (vecs[i]) begin
         send(vecs[i].sel, vecs[i].word, 1'b0);
         eb = '0;
         for (int b = 0; b < 4; b++) eb[b] = vecs[i].exp[b];
         check_bytes(vecs[i].sel, 4, eb, $sformatf("vec%0d", i));
      end

      // randomized words on both dividers
      for (int i = 0; i < 6; i++) begin
         rw = $urandom;
         send(i[0], rw, 1'b0);
         eb = '0;
         for (int b = 0; b < 4; b++) eb[b] = 8'((rw >> (8 * b)) & 32'hFF);
         check_bytes(i[0], 4, eb, $sformatf("rnd%0d", i));
      end

      // handshake gating while busy
      send(1'b0, 32'h1357_9BDF, 1'b1);
      repeat (200) @(negedge clk);
      chk("gate_idle_ready", 32'(if4.word_ready), 32'd1);
      eb = '0;
      eb[3:0] = {8'h13, 8'h57, 8'h9B, 8'hDF};
      check_bytes(1'b0, 4, eb, "gate");

      // back-to-back with word_valid held high
      wait_ready(1'b0);
      drive(1'b0, 32'h0000_0001, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 32'hDEAD_BEEF, 1'b1);
      for (int k = 0; k < 321; k++) begin
         if (k < 160)       chk($sformatf("b2b tx k=%0d", k), 32'(tx4), 32'(exp_tx(32'h1, k, C4)));
         else if (k == 160) begin
            chk("b2b_gap_tx", 32'(tx4), 32'd1);
            chk("b2b_done0", 32'(done4), 32'd1);
         end else begin
            if (k == 161) drive(1'b0, 32'h0, 1'b0);
            chk($sformatf("b2b tx k=%0d", k), 32'(tx4), 32'(exp_tx(32'hDEAD_BEEF, k - 161, C4)));
         end
         @(negedge clk);
      end
      chk("b2b_done1", 32'(done4), 32'd1);
      @(negedge clk);
      eb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
      check_bytes(1'b0, 8, eb, "b2b");

      // reset during byte 2 data bits
      wait_ready(1'b0);
      drive(1'b0, 32'hCAFE_F00D, 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0);
      repeat (90) @(negedge clk);
      chk("pre_rst_busy", 32'(busy4), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_tx", 32'(tx4), 32'd1);
      chk("midrst_ready", 32'(if4.word_ready), 32'd1);
      chk("midrst_busy", 32'(busy4), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("postrst_tx", 32'(tx4), 32'd1);
      rxq4.delete();
      send(1'b0, 32'h1234_5678, 1'b0);
      eb = '0;
      eb[3:0] = {8'h12, 8'h34, 8'h56, 8'h78};
      check_bytes(1'b0, 4, eb, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
